// File: rtl/arbitro_memoria_dados_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Shared by the top and the priority selector.
package arbitro_memoria_dados_pkg;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    ACESSO   = 2'd1,
    RESPOSTA = 2'd2
  } estado_t;

  localparam int LARGURA_DADO_PAD = 8;
  localparam int LARGURA_END_PAD  = 8;
  localparam int LARGURA_CONT     = 4;

  localparam logic P_CPU = 1'b0;
  localparam logic P_DBG = 1'b1;

endpackage

// File: rtl/arbitro_memoria_dados_seletor.sv
// Combinational winner selection for the two requesters.
// Supports round-robin or port-0 priority with a starvation limit.
module arbitro_memoria_dados_seletor
  import arbitro_memoria_dados_pkg::*;
#(
  parameter int MAX_CONCESSOES = 4
) (
  input  logic                    req0,
  input  logic                    req1,
  input  logic                    ultimo,
  input  logic                    modo_fixo,
  input  logic [LARGURA_CONT-1:0] contador,
  output logic                    ven,
  output logic                    valido
);

  localparam logic [LARGURA_CONT-1:0] LIMITE =
    LARGURA_CONT'(MAX_CONCESSOES);

  logic ambos;
  logic esgotado;

  always_comb begin
    ambos    = req0 & req1;
    esgotado = (contador == LIMITE);
    valido   = req0 | req1;
    ven      = P_CPU;
    unique case (1'b1)
      (ambos && modo_fixo):  ven = esgotado;
      (ambos && !modo_fixo): ven = ~ultimo;
      (req1 && !req0):       ven = P_DBG;
      default:               ven = P_CPU;
    endcase
  end

endmodule

// File: rtl/arbitro_memoria_dados.sv
// Two-port arbiter/sequencer in front of the single-port data memory.
// Every transaction takes OCIOSO -> ACESSO -> RESPOSTA, all outputs registered.
module arbitro_memoria_dados
  import arbitro_memoria_dados_pkg::*;
#(
  parameter int LARGURA_DADO    = LARGURA_DADO_PAD,
  parameter int LARGURA_END     = LARGURA_END_PAD,
  parameter int PRIORIDADE_FIXA = 0,
  parameter int MAX_CONCESSOES  = 4
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    Req0,
  input  logic                    Req1,
  input  logic                    Esc0,
  input  logic                    Esc1,
  input  logic [LARGURA_END-1:0]  End0,
  input  logic [LARGURA_END-1:0]  End1,
  input  logic [LARGURA_DADO-1:0] Dado0,
  input  logic [LARGURA_DADO-1:0] Dado1,
  output logic                    Ack0,
  output logic                    Ack1,
  output logic [LARGURA_DADO-1:0] DadoLidoSaida,
  output logic [LARGURA_END-1:0]  MemEndereco,
  output logic [LARGURA_DADO-1:0] MemDadoEscrito,
  output logic                    MemEscMem,
  output logic                    MemLerMem,
  input  logic [LARGURA_DADO-1:0] MemDadoLido
);

  localparam logic [LARGURA_CONT-1:0] CONT_MAX = '1;

  estado_t estado_q;
  estado_t estado_d;

  logic ven_q;
  logic ven_d;
  logic ultimo_q;
  logic ultimo_d;
  logic ack0_q;
  logic ack0_d;
  logic ack1_q;
  logic ack1_d;
  logic esc_q;
  logic esc_d;
  logic ler_q;
  logic ler_d;

  logic [LARGURA_CONT-1:0] contador_q;
  logic [LARGURA_CONT-1:0] contador_d;
  logic [LARGURA_END-1:0]  end_q;
  logic [LARGURA_END-1:0]  end_d;
  logic [LARGURA_DADO-1:0] dw_q;
  logic [LARGURA_DADO-1:0] dw_d;
  logic [LARGURA_DADO-1:0] lido_q;
  logic [LARGURA_DADO-1:0] lido_d;

  logic ven;
  logic valido;
  logic modo_fixo;

  assign modo_fixo = (PRIORIDADE_FIXA != 0);

  arbitro_memoria_dados_seletor #(
    .MAX_CONCESSOES(MAX_CONCESSOES)
  ) u_seletor (
    .req0      (Req0),
    .req1      (Req1),
    .ultimo    (ultimo_q),
    .modo_fixo (modo_fixo),
    .contador  (contador_q),
    .ven       (ven),
    .valido    (valido)
  );

  always_comb begin
    estado_d   = estado_q;
    ven_d      = ven_q;
    ultimo_d   = ultimo_q;
    contador_d = contador_q;
    end_d      = end_q;
    dw_d       = dw_q;
    lido_d     = lido_q;
    esc_d      = esc_q;
    ler_d      = ler_q;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;
    unique case (estado_q)
      OCIOSO: begin
        // Starvation counter only runs while port 1 is kept waiting
        if (!Req1 || ven) begin
          contador_d = '0;
        end else if (contador_q != CONT_MAX) begin
          contador_d = contador_q + 1'b1;
        end
        if (valido) begin
          ven_d    = ven;
          ultimo_d = ven;
          end_d    = ven ? End1 : End0;
          dw_d     = ven ? Dado1 : Dado0;
          esc_d    = ven ? Esc1 : Esc0;
          ler_d    = ven ? ~Esc1 : ~Esc0;
          estado_d = ACESSO;
        end
      end
      ACESSO: begin
        if (ler_q) begin
          lido_d = MemDadoLido;
        end
        esc_d    = 1'b0;
        ler_d    = 1'b0;
        ack0_d   = ~ven_q;
        ack1_d   = ven_q;
        estado_d = RESPOSTA;
      end
      RESPOSTA: begin
        estado_d = OCIOSO;
      end
      default: begin
        estado_d = OCIOSO;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      estado_q   <= OCIOSO;
      ven_q      <= P_CPU;
      ultimo_q   <= 1'b1;
      contador_q <= '0;
      end_q      <= '0;
      dw_q       <= '0;
      lido_q     <= '0;
      esc_q      <= 1'b0;
      ler_q      <= 1'b0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      ven_q      <= ven_d;
      ultimo_q   <= ultimo_d;
      contador_q <= contador_d;
      end_q      <= end_d;
      dw_q       <= dw_d;
      lido_q     <= lido_d;
      esc_q      <= esc_d;
      ler_q      <= ler_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
    end
  end

  assign Ack0           = ack0_q;
  assign Ack1           = ack1_q;
  assign DadoLidoSaida  = lido_q;
  assign MemEndereco    = end_q;
  assign MemDadoEscrito = dw_q;
  assign MemEscMem      = esc_q;
  assign MemLerMem      = ler_q;

endmodule
